// File: rtl/expr_pkg.sv
// Shared constants for the expression string transmitter: ASCII codes,
// operator encodings and the FSM state encoding.
package expr_pkg;

  localparam logic [7:0] ASCII_NUL   = 8'h00;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_EQ    = 8'h3D;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [3:0] MAX_DIGIT = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DIG  = 3'd1,
    ST_OP   = 3'd2,
    ST_TERM = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

endpackage

// File: rtl/expr_ascii_enc.sv
// Combinational map from {is_op, code} to an ASCII character plus a legality
// flag; illegal codes yield 8'h00.
module expr_ascii_enc
  import expr_pkg::*;
(
  input  logic       is_op,
  input  logic [3:0] code,
  output logic [7:0] ascii,
  output logic       legal
);

  // Operator codes use only the low two bits; any upper bit set is illegal.
  always_comb begin
    ascii = ASCII_NUL;
    legal = 1'b0;
    if (is_op) begin
      if (code[3:2] == 2'b00) begin
        case (code[1:0])
          OP_ADD:  begin ascii = ASCII_PLUS;  legal = 1'b1; end
          OP_MUL:  begin ascii = ASCII_STAR;  legal = 1'b1; end
          OP_SUB:  begin ascii = ASCII_MINUS; legal = 1'b1; end
          default: begin ascii = ASCII_NUL;   legal = 1'b0; end
        endcase
      end else begin
        ascii = ASCII_NUL;
        legal = 1'b0;
      end
    end else if (code <= MAX_DIGIT) begin
      ascii = ASCII_ZERO + {4'h0, code};
      legal = 1'b1;
    end else begin
      ascii = ASCII_NUL;
      legal = 1'b0;
    end
  end

endmodule

// File: rtl/expr_string_tx.sv
// Streams a BCD arithmetic expression (digit, op, digit, ...) as ASCII over a
// valid/ready handshake, with an optional terminator character.
module expr_string_tx
  import expr_pkg::*;
#(
  parameter bit         TERM_EN   = 1'b0,
  parameter logic [7:0] TERM_CHAR = 8'h3D
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [1:0]  num_ops,
  input  logic [15:0] digits,
  input  logic [5:0]  ops,
  input  logic        out_ready,
  output logic [7:0]  out,
  output logic        out_valid,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t      state_r, nxt_state_s;
  logic [1:0]  idx_r, nxt_idx_s;
  logic [1:0]  num_ops_r;
  logic [15:0] digits_r;
  logic [5:0]  ops_r;
  logic [7:0]  out_r;
  logic        out_valid_r, busy_r, done_r, err_r;

  logic        load_s, err_s, legal_s;
  logic [3:0]  dig_legal_s, dig_used_s;
  logic [2:0]  op_legal_s, op_used_s;
  logic [7:0]  unused_dig_ascii_s [4];
  logic [7:0]  unused_op_ascii_s [3];

  logic [15:0] src_digits_s;
  logic [7:0]  src_ops_s;
  logic        enc_is_op_s, enc_legal_s;
  logic [3:0]  enc_code_s;
  logic [7:0]  enc_ascii_s, nxt_out_s;

  // Start validation: every used field must encode legally; unused ones are masked.
  for (genvar k = 0; k < 4; k++) begin : g_dig_chk
    expr_ascii_enc u_dig_chk (
      .is_op (1'b0),
      .code  (digits[4*k +: 4]),
      .ascii (unused_dig_ascii_s[k]),
      .legal (dig_legal_s[k])
    );
    assign dig_used_s[k] = (num_ops >= 2'(k));
  end

  for (genvar k = 0; k < 3; k++) begin : g_op_chk
    expr_ascii_enc u_op_chk (
      .is_op (1'b1),
      .code  ({2'b00, ops[2*k +: 2]}),
      .ascii (unused_op_ascii_s[k]),
      .legal (op_legal_s[k])
    );
    assign op_used_s[k] = (num_ops > 2'(k));
  end

  assign legal_s = (&(dig_legal_s | ~dig_used_s)) & (&(op_legal_s | ~op_used_s));

  // Next-state and index logic; every state holds while out_ready is low.
  always_comb begin
    nxt_state_s = state_r;
    nxt_idx_s   = idx_r;
    load_s      = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (legal_s) begin
            load_s      = 1'b1;
            nxt_idx_s   = 2'd0;
            nxt_state_s = ST_DIG;
          end else begin
            err_s       = 1'b1;
            nxt_state_s = ST_IDLE;
          end
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_DIG: begin
        if (out_ready) begin
          if (idx_r < num_ops_r) begin
            nxt_state_s = ST_OP;
          end else if (TERM_EN) begin
            nxt_state_s = ST_TERM;
          end else begin
            nxt_state_s = ST_FIN;
          end
        end else begin
          nxt_state_s = ST_DIG;
        end
      end
      ST_OP: begin
        if (out_ready) begin
          nxt_idx_s   = idx_r + 2'd1;
          nxt_state_s = ST_DIG;
        end else begin
          nxt_state_s = ST_OP;
        end
      end
      ST_TERM: begin
        if (out_ready) begin
          nxt_state_s = ST_FIN;
        end else begin
          nxt_state_s = ST_TERM;
        end
      end
      ST_FIN:  nxt_state_s = ST_IDLE;
      default: nxt_state_s = ST_IDLE;
    endcase
  end

  // The output character is precomputed from the next state so out is registered
  // yet still appears one cycle after start; on the load cycle the fields come
  // straight from the inputs.
  always_comb begin
    src_digits_s = load_s ? digits : digits_r;
    src_ops_s    = load_s ? {2'b00, ops} : {2'b00, ops_r};
    enc_is_op_s  = (nxt_state_s == ST_OP);
    if (enc_is_op_s) begin
      enc_code_s = {2'b00, src_ops_s[{nxt_idx_s, 1'b0} +: 2]};
    end else begin
      enc_code_s = src_digits_s[{nxt_idx_s, 2'b00} +: 4];
    end
  end

  expr_ascii_enc u_out_enc (
    .is_op (enc_is_op_s),
    .code  (enc_code_s),
    .ascii (enc_ascii_s),
    .legal (enc_legal_s)
  );

  // Character to register for the next cycle; NUL whenever nothing is valid.
  always_comb begin
    nxt_out_s = ASCII_NUL;
    case (nxt_state_s)
      ST_DIG, ST_OP: nxt_out_s = enc_legal_s ? enc_ascii_s : ASCII_NUL;
      ST_TERM:       nxt_out_s = TERM_CHAR;
      default:       nxt_out_s = ASCII_NUL;
    endcase
  end

  // State, index, latched fields and registered outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r     <= ST_IDLE;
      idx_r       <= 2'd0;
      num_ops_r   <= 2'd0;
      digits_r    <= 16'h0000;
      ops_r       <= 6'b000000;
      out_r       <= ASCII_NUL;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r <= nxt_state_s;
      idx_r   <= nxt_idx_s;
      if (load_s) begin
        num_ops_r <= num_ops;
        digits_r  <= digits;
        ops_r     <= ops;
      end else begin
        num_ops_r <= num_ops_r;
        digits_r  <= digits_r;
        ops_r     <= ops_r;
      end
      out_r       <= nxt_out_s;
      out_valid_r <= (nxt_state_s == ST_DIG) || (nxt_state_s == ST_OP) ||
                     (nxt_state_s == ST_TERM);
      busy_r      <= (nxt_state_s != ST_IDLE);
      done_r      <= (nxt_state_s == ST_FIN);
      err_r       <= err_s;
    end
  end

  assign out       = out_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_expr_string_tx.sv
// Self-checking bench: two instances (terminator off/on) share stimulus and are
// checked against a string-building reference model.
module tb_expr_string_tx;

  logic        clk = 1'b0;
  logic        clr, start, out_ready;
  logic [1:0]  num_ops;
  logic [15:0] digits;
  logic [5:0]  ops;
  logic [7:0]  out0, out1;
  logic        out_valid0, busy0, done0, err0;
  logic        out_valid1, busy1, done1, err1;

  int tests = 0;
  int fails = 0;
  byte exp0[$], exp1[$], got0[$], got1[$];
  bit  exp_err;
  int  done_cnt0, done_cnt1, err_cnt0, err_cnt1, busy_cnt0, busy_cnt1, zero_viol;
  bit  to;

  expr_string_tx #(.TERM_EN(1'b0), .TERM_CHAR(8'h3D)) dut0 (
    .clk(clk), .clr(clr), .start(start), .num_ops(num_ops), .digits(digits),
    .ops(ops), .out_ready(out_ready), .out(out0), .out_valid(out_valid0),
    .busy(busy0), .done(done0), .err(err0));

  expr_string_tx #(.TERM_EN(1'b1), .TERM_CHAR(8'h3D)) dut1 (
    .clk(clk), .clr(clr), .start(start), .num_ops(num_ops), .digits(digits),
    .ops(ops), .out_ready(out_ready), .out(out1), .out_valid(out_valid1),
    .busy(busy1), .done(done1), .err(err1));

  always #5 clk = ~clk;

  // Record accepted characters and pulse counts away from the rising edge.
  always @(negedge clk) begin
    if (out_valid0 && out_ready) got0.push_back(out0);
    if (out_valid1 && out_ready) got1.push_back(out1);
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
    if (err0) err_cnt0++;
    if (err1) err_cnt1++;
    if (busy0) busy_cnt0++;
    if (busy1) busy_cnt1++;
    if ((!out_valid0 && out0 !== 8'h00) || (!out_valid1 && out1 !== 8'h00)) zero_viol++;
  end

  function automatic string q2s(input byte q[$]);
    string s = "";
    foreach (q[i]) s = $sformatf("%s%c", s, q[i]);
    return s;
  endfunction

  // Reference: the expression is just digits interleaved with operator symbols.
  function automatic void build_expected(input int n, input logic [15:0] d, input logic [5:0] o);
    string opch = "+*-";
    byte zc = "0";
    byte eq = "=";
    int dv, ov;
    exp0.delete();
    exp1.delete();
    exp_err = 1'b0;
    for (int i = 0; i <= n; i++) if (int'((d >> (4 * i)) & 16'hF) > 9) exp_err = 1'b1;
    for (int i = 0; i < n; i++) if (int'((o >> (2 * i)) & 6'h3) == 3) exp_err = 1'b1;
    if (!exp_err) begin
      for (int i = 0; i <= n; i++) begin
        dv = int'((d >> (4 * i)) & 16'hF);
        exp0.push_back(byte'(zc + dv));
        if (i < n) begin
          ov = int'((o >> (2 * i)) & 6'h3);
          exp0.push_back(opch[ov]);
        end
      end
      foreach (exp0[i]) exp1.push_back(exp0[i]);
      exp1.push_back(eq);
    end
  endfunction

  task automatic clear_stats();
    got0.delete(); got1.delete();
    done_cnt0 = 0; done_cnt1 = 0; err_cnt0 = 0; err_cnt1 = 0;
    busy_cnt0 = 0; busy_cnt1 = 0;
  endtask

  task automatic send(input logic [1:0] n, input logic [15:0] d, input logic [5:0] o);
    @(posedge clk); #1;
    num_ops = n; digits = d; ops = o; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rnd_ready, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk); #1;
      if (!busy0 && !busy1) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    clr = 1'b0; start = 1'b0; num_ops = 2'd0; digits = 16'h0; ops = 6'h0; out_ready = 1'b1;
    #23;
    tests++;
    if ({out0, out_valid0, busy0, done0, err0} !== 12'h000) begin
      fails++; $display("FAIL reset0: got %h want 000", {out0, out_valid0, busy0, done0, err0});
    end
    tests++;
    if ({out1, out_valid1, busy1, done1, err1} !== 12'h000) begin
      fails++; $display("FAIL reset1: got %h want 000", {out1, out_valid1, busy1, done1, err1});
    end
    @(posedge clk); #1; clr = 1'b1;
    clear_stats();
  endtask

  task automatic test_basic();
    clear_stats();
    build_expected(2, 16'h0321, 6'b00_01_00);
    send(2'd2, 16'h0321, 6'b00_01_00);
    wait_idle(40, 1'b0, to);
    tests++;
    if (to) begin fails++; $display("FAIL basic_timeout: busy never dropped"); end
    tests++;
    if (q2s(got0) != "1+2*3") begin
      fails++; $display("FAIL basic_str0: got '%s' want '1+2*3'", q2s(got0));
    end
    tests++;
    if (q2s(got1) != q2s(exp1)) begin
      fails++; $display("FAIL basic_str1: got '%s' want '%s'", q2s(got1), q2s(exp1));
    end
    tests++;
    if (done_cnt0 != 1 || done_cnt1 != 1) begin
      fails++; $display("FAIL basic_done: got %0d/%0d want 1/1", done_cnt0, done_cnt1);
    end
    tests++;
    if (busy_cnt0 != exp0.size() + 1 || busy_cnt1 != exp1.size() + 1) begin
      fails++; $display("FAIL basic_cycles: got %0d/%0d want %0d/%0d",
                        busy_cnt0, busy_cnt1, exp0.size() + 1, exp1.size() + 1);
    end
  endtask

  task automatic test_term();
    clear_stats();
    build_expected(0, 16'hBCD7, 6'h3F);
    send(2'd0, 16'hBCD7, 6'h3F);
    wait_idle(40, 1'b0, to);
    tests++;
    if (q2s(got1) != "7=" || q2s(got0) != "7") begin
      fails++; $display("FAIL term_str: got '%s' and '%s' want '7=' and '7'", q2s(got1), q2s(got0));
    end
    tests++;
    if (busy_cnt1 != 3) begin
      fails++; $display("FAIL term_busy: got %0d want 3", busy_cnt1);
    end
    tests++;
    if (done_cnt1 != 1 || err_cnt1 != 0) begin
      fails++; $display("FAIL term_done: got done=%0d err=%0d want 1/0", done_cnt1, err_cnt1);
    end
  endtask

  task automatic test_stall();
    clear_stats();
    build_expected(1, 16'h0054, 6'b00_00_00);
    out_ready = 1'b1;
    send(2'd1, 16'h0054, 6'b00_00_00);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      tests++;
      if (out0 !== 8'h2B || out_valid0 !== 1'b1 || out1 !== 8'h2B || out_valid1 !== 1'b1) begin
        fails++; $display("FAIL stall_hold%0d: got %h/%b %h/%b want 2b/1", c, out0, out_valid0, out1, out_valid1);
      end
    end
    tests++;
    if (got0.size() != 1) begin
      fails++; $display("FAIL stall_advance: got %0d chars want 1", got0.size());
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle(40, 1'b0, to);
    tests++;
    if (q2s(got0) != q2s(exp0) || q2s(got1) != q2s(exp1)) begin
      fails++; $display("FAIL stall_str: got '%s' and '%s' want '%s' and '%s'",
                        q2s(got0), q2s(got1), q2s(exp0), q2s(exp1));
    end
  endtask

  task automatic test_illegal();
    clear_stats();
    send(2'd1, 16'h00A3, 6'h00);
    wait_idle(40, 1'b0, to);
    tests++;
    if (err_cnt0 != 1 || err_cnt1 != 1) begin
      fails++; $display("FAIL illegal_err: got %0d/%0d want 1/1", err_cnt0, err_cnt1);
    end
    tests++;
    if (got0.size() + got1.size() != 0 || busy_cnt0 + busy_cnt1 != 0 || done_cnt0 != 0) begin
      fails++; $display("FAIL illegal_quiet: got chars=%0d busy=%0d done=%0d want 0",
                        got0.size() + got1.size(), busy_cnt0 + busy_cnt1, done_cnt0);
    end
    clear_stats();
    build_expected(0, 16'h00A3, 6'h00);
    send(2'd0, 16'h00A3, 6'h00);
    wait_idle(40, 1'b0, to);
    tests++;
    if (err_cnt0 != 0 || q2s(got0) != "3" || q2s(got1) != "3=") begin
      fails++; $display("FAIL unused_field: got err=%0d '%s' and '%s' want 0 '3' and '3='",
                        err_cnt0, q2s(got0), q2s(got1));
    end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    out_ready = 1'b1;
    send(2'd2, 16'h0987, 6'b00_00_10);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (got0.size() >= 2) break;
    end
    @(posedge clk); #2;
    clr = 1'b0;
    #1;
    tests++;
    if ({out0, out_valid0, out1, out_valid1, busy0, busy1} !== 20'h0) begin
      fails++; $display("FAIL midreset_out: got %h/%b %h/%b busy=%b%b want 00/0",
                        out0, out_valid0, out1, out_valid1, busy0, busy1);
    end
    repeat (3) @(posedge clk);
    #1; clr = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    tests++;
    if (got0.size() != 2 || got1.size() != 2 || done_cnt0 + done_cnt1 != 0) begin
      fails++; $display("FAIL midreset_abandon: got chars=%0d/%0d done=%0d want 2/2 0",
                        got0.size(), got1.size(), done_cnt0 + done_cnt1);
    end
    clear_stats();
    build_expected(2, 16'h0642, 6'b00_10_01);
    send(2'd2, 16'h0642, 6'b00_10_01);
    wait_idle(40, 1'b0, to);
    tests++;
    if (q2s(got0) != q2s(exp0) || q2s(got1) != q2s(exp1) || done_cnt0 != 1) begin
      fails++; $display("FAIL midreset_resume: got '%s' and '%s' done=%0d want '%s' and '%s' 1",
                        q2s(got0), q2s(got1), done_cnt0, q2s(exp0), q2s(exp1));
    end
  endtask

  task automatic test_back_to_back();
    clear_stats();
    build_expected(3, 16'h1234, 6'b00_01_10);
    send(2'd3, 16'h1234, 6'b00_01_10);
    @(posedge clk); #1;
    num_ops = 2'd1; digits = 16'h5678; ops = 6'b11_11_11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; digits = 16'hFFFF;
    wait_idle(40, 1'b0, to);
    tests++;
    if (q2s(got0) != "4-3*2+1" || q2s(got1) != q2s(exp1)) begin
      fails++; $display("FAIL b2b_str: got '%s' and '%s' want '4-3*2+1' and '%s'",
                        q2s(got0), q2s(got1), q2s(exp1));
    end
    tests++;
    if (done_cnt0 != 1 || err_cnt0 != 0 || done_cnt1 != 1) begin
      fails++; $display("FAIL b2b_pulses: got done=%0d err=%0d want 1/0", done_cnt0, err_cnt0);
    end
  endtask

  task automatic test_random();
    logic [1:0]  n;
    logic [15:0] d;
    logic [5:0]  o;
    for (int it = 0; it < 40; it++) begin
      n = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++)
        d[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      for (int k = 0; k < 3; k++)
        o[2*k +: 2] = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      clear_stats();
      build_expected(int'(n), d, o);
      send(n, d, o);
      wait_idle(100, 1'b1, to);
      tests++;
      if (to || q2s(got0) != q2s(exp0) || q2s(got1) != q2s(exp1)) begin
        fails++; $display("FAIL rand%0d_str: n=%0d d=%h o=%b got '%s' and '%s' want '%s' and '%s' to=%b",
                          it, n, d, o, q2s(got0), q2s(got1), q2s(exp0), q2s(exp1), to);
      end
      tests++;
      if (err_cnt0 != int'(exp_err) || err_cnt1 != int'(exp_err) ||
          done_cnt0 != int'(!exp_err) || done_cnt1 != int'(!exp_err)) begin
        fails++; $display("FAIL rand%0d_pulses: got err=%0d/%0d done=%0d/%0d want err=%0d done=%0d",
                          it, err_cnt0, err_cnt1, done_cnt0, done_cnt1, exp_err, !exp_err);
      end
    end
    tests++;
    if (zero_viol != 0) begin
      fails++; $display("FAIL idle_nul: got %0d non-zero idle chars want 0", zero_viol);
    end
  endtask

  initial begin
    zero_viol = 0;
    test_reset();
    test_basic();
    test_term();
    test_stall();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
